fp_issue_ctrl: RTL and testbench

// Issue/sequencing front end for the FPU: accepts 32-bit FP instruction words from the CPU

---
 rtl/fp_issue_ctrl_if.sv | 40 ++++
 rtl/fp_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_fp_issue_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fp_issue_ctrl_if.sv
// fp_issue_ctrl_if
// Purpose: bundles the CPU instruction handshake and the decoded FPU datapath
//          controls driven by fp_issue_ctrl.
// Signals:
//   instr_valid, instr      CPU -> issue ctrl: instruction offer
//   instr_ready             issue ctrl -> CPU: instruction can be accepted
//   fp_alu_src, fp_reg_dst,
//   fp_alu_ctrl, Rs, Rt,
//   Rd, immediate           decoded fields of the held instruction
//   fp_reg_write            one-cycle write strobe at completion
//   illegal_instr           one-cycle pulse on an undecodable accepted instr
//   retire_count            completed operation count (wraps)
// Modports: master = CPU side, slave = fp_issue_ctrl.
interface fp_issue_ctrl_if;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        fp_alu_src;
   logic        fp_reg_dst;
   logic [2:0]  fp_alu_ctrl;
   logic [4:0]  Rs;
   logic [4:0]  Rt;
   logic [4:0]  Rd;
   logic [15:0] immediate;
   logic        fp_reg_write;
   logic        illegal_instr;
   logic [15:0] retire_count;

   modport master (
      output instr_valid, instr,
      input  instr_ready, fp_alu_src, fp_reg_dst, fp_alu_ctrl, Rs, Rt, Rd,
             immediate, fp_reg_write, illegal_instr, retire_count
   );

   modport slave (
      input  instr_valid, instr,
      output instr_ready, fp_alu_src, fp_reg_dst, fp_alu_ctrl, Rs, Rt, Rd,
             immediate, fp_reg_write, illegal_instr, retire_count
   );
endinterface

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl
// Purpose: FPU issue front end. Accepts one FP instruction at a time over a
//          valid/ready handshake, decodes it, holds the datapath controls stable
//          for the operation latency and pulses fp_reg_write in the final cycle.
// Ports:
//   cpu_clk  in  sole clock, rising edge
//   reset    in  synchronous, active-high
//   bus      fp_issue_ctrl_if.slave (handshake in, registered controls out)
// Parameters: ADD_LAT / MUL_LAT / DIV_LAT / SQRT_LAT, cycles held per op (1..255).
module fp_issue_ctrl #(
   parameter int unsigned ADD_LAT  = 1,
   parameter int unsigned MUL_LAT  = 2,
   parameter int unsigned DIV_LAT  = 8,
   parameter int unsigned SQRT_LAT = 16
) (
   input logic           cpu_clk,
   input logic           reset,
   fp_issue_ctrl_if.slave bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q;
   logic [25:0] hold_q;     // opcode bits are not needed once decoded
   logic [7:0]  cnt_q;
   logic [2:0]  ctrl_q;
   logic        src_q;
   logic        dst_q;
   logic        ready_q;
   logic        write_q;
   logic        illegal_q;
   logic [15:0] retire_q;

   logic        dec_legal_d;
   logic [2:0]  dec_ctrl_d;
   logic        dec_src_d;
   logic        dec_dst_d;
   logic [7:0]  dec_cnt_d;

   // Decode of the offered word; only consumed on the accept edge.
   always_comb begin
      dec_legal_d = 1'b0;
      dec_ctrl_d  = '0;
      dec_src_d   = 1'b0;
      dec_dst_d   = 1'b0;
      if (bus.instr[31:26] == 6'h11 && bus.instr[5:0] <= 6'd4) begin
         dec_legal_d = 1'b1;
         dec_ctrl_d  = bus.instr[2:0];
         dec_dst_d   = 1'b1;
      end else if (bus.instr[31:28] == 4'hE && bus.instr[27:26] != 2'b00 ||
                   bus.instr[31:26] == 6'h38) begin
         // 6'h38..6'h3B: immediate add/sub/mul/div
         dec_legal_d = 1'b1;
         dec_ctrl_d  = {1'b0, bus.instr[27:26]};
         dec_src_d   = 1'b1;
      end
      case (dec_ctrl_d)
         3'd0, 3'd1: dec_cnt_d = 8'(ADD_LAT - 1);
         3'd2:       dec_cnt_d = 8'(MUL_LAT - 1);
         3'd3:       dec_cnt_d = 8'(DIV_LAT - 1);
         default:    dec_cnt_d = 8'(SQRT_LAT - 1);
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         cnt_q     <= '0;
         ctrl_q    <= '0;
         src_q     <= 1'b0;
         dst_q     <= 1'b0;
         ready_q   <= 1'b0;
         write_q   <= 1'b0;
         illegal_q <= 1'b0;
         retire_q  <= '0;
      end else begin
         write_q   <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (bus.instr_valid && ready_q) begin
                  hold_q <= bus.instr[25:0];
                  if (dec_legal_d) begin
                     ctrl_q  <= dec_ctrl_d;
                     src_q   <= dec_src_d;
                     dst_q   <= dec_dst_d;
                     cnt_q   <= dec_cnt_d;
                     state_q <= BUSY;
                     ready_q <= 1'b0;
                     // Single-cycle ops strobe in the very first BUSY cycle.
                     write_q <= (dec_cnt_d == 8'd0);
                  end else begin
                     illegal_q <= 1'b1;
                  end
               end
            end
            BUSY: begin
               if (cnt_q == 8'd0) begin
                  state_q  <= IDLE;
                  ready_q  <= 1'b1;
                  retire_q <= retire_q + 16'd1;
               end else begin
                  cnt_q   <= cnt_q - 8'd1;
                  write_q <= (cnt_q == 8'd1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.instr_ready   = ready_q;
   assign bus.fp_alu_src    = src_q;
   assign bus.fp_reg_dst    = dst_q;
   assign bus.fp_alu_ctrl   = ctrl_q;
   assign bus.Rs            = hold_q[25:21];
   assign bus.Rt            = hold_q[20:16];
   assign bus.Rd            = hold_q[15:11];
   assign bus.immediate     = hold_q[15:0];
   assign bus.fp_reg_write  = write_q;
   assign bus.illegal_instr = illegal_q;
   assign bus.retire_count  = retire_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
module tb_fp_issue_ctrl;

   logic clk;
   logic rst;
   int unsigned n_chk;
   int unsigned n_pass;
   logic [15:0] exp_retire;

   fp_issue_ctrl_if bus ();

   fp_issue_ctrl #(
      .ADD_LAT (1),
      .MUL_LAT (2),
      .DIV_LAT (8),
      .SQRT_LAT(16)
   ) dut (
      .cpu_clk(clk),
      .reset  (rst),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        legal;
      logic [2:0]  ctrl;
      logic        src;
      logic        dst;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      int unsigned lat;
      logic        hold;   // keep instr_valid high (other word) during BUSY
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic chk_dp(input vec_t v, input string tag);
      chk({tag, " ctrl"}, 32'(bus.fp_alu_ctrl), 32'(v.ctrl));
      chk({tag, " src"},  32'(bus.fp_alu_src),  32'(v.src));
      chk({tag, " dst"},  32'(bus.fp_reg_dst),  32'(v.dst));
      chk({tag, " Rs"},   32'(bus.Rs),          32'(v.rs));
      chk({tag, " Rt"},   32'(bus.Rt),          32'(v.rt));
      chk({tag, " Rd"},   32'(bus.Rd),          32'(v.rd));
      chk({tag, " imm"},  32'(bus.immediate),   32'(v.imm));
   endtask

   task automatic run_vec(input vec_t v, input int unsigned idx);
      string tag;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      chk({tag, " ready_pre"}, 32'(bus.instr_ready), 32'd1);
      bus.instr_valid = 1'b1;
      bus.instr       = v.instr;
      @(negedge clk);                      // cycle T+1
      if (v.hold) bus.instr = 32'h44A41004;
      else        bus.instr_valid = 1'b0;
      if (v.legal) begin
         for (int unsigned k = 1; k <= v.lat; k++) begin
            chk($sformatf("%s busy_ready c%0d", tag, k), 32'(bus.instr_ready), 32'd0);
            chk($sformatf("%s write c%0d", tag, k), 32'(bus.fp_reg_write), 32'(k == v.lat));
            chk_dp(v, $sformatf("%s c%0d", tag, k));
            if (k < v.lat) @(negedge clk);
         end
         exp_retire = exp_retire + 16'd1;
         @(negedge clk);                   // cycle T+LAT+1
         bus.instr_valid = 1'b0;
         chk({tag, " ready_post"}, 32'(bus.instr_ready), 32'd1);
         chk({tag, " write_post"}, 32'(bus.fp_reg_write), 32'd0);
         chk({tag, " retire"}, 32'(bus.retire_count), 32'(exp_retire));
         chk_dp(v, {tag, " idle"});
      end else begin
         chk({tag, " illegal"}, 32'(bus.illegal_instr), 32'd1);
         chk({tag, " ill_write"}, 32'(bus.fp_reg_write), 32'd0);
         chk({tag, " ill_ready"}, 32'(bus.instr_ready), 32'd1);
         @(negedge clk);
         chk({tag, " ill_pulse_end"}, 32'(bus.illegal_instr), 32'd0);
         chk({tag, " ill_retire"}, 32'(bus.retire_count), 32'(exp_retire));
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int unsigned strobes;
      int unsigned cycles;
      n_chk = 0;
      n_pass = 0;
      exp_retire = '0;

      vecs[0] = '{32'h44A41000, 1'b1, 3'd0, 1'b0, 1'b1, 5'd5,  5'd4,  5'd2, 16'h1000, 1,  1'b0};
      vecs[1] = '{32'hE8C73F80, 1'b1, 3'd2, 1'b1, 1'b0, 5'd6,  5'd7,  5'd7, 16'h3F80, 2,  1'b1};
      vecs[2] = '{32'h44A41004, 1'b1, 3'd4, 1'b0, 1'b1, 5'd5,  5'd4,  5'd2, 16'h1004, 16, 1'b0};
      vecs[3] = '{32'h00000000, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 16'h0000, 0,  1'b0};
      vecs[4] = '{32'h44A41001, 1'b1, 3'd1, 1'b0, 1'b1, 5'd5,  5'd4,  5'd2, 16'h1001, 1,  1'b0};
      vecs[5] = '{32'hEDEF0005, 1'b1, 3'd3, 1'b1, 1'b0, 5'd15, 5'd15, 5'd0, 16'h0005, 8,  1'b1};
      vecs[6] = '{32'h44A41005, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 16'h0000, 0,  1'b0};
      vecs[7] = '{32'hE0220010, 1'b1, 3'd0, 1'b1, 1'b0, 5'd1,  5'd2,  5'd0, 16'h0010, 1,  1'b0};
      vecs[8] = '{32'hF0000000, 1'b0, 3'd0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 16'h0000, 0,  1'b0};

      // Reset for two cycles: everything reads zero while reset is high.
      rst = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr = '0;
      @(negedge clk);
      chk("rst ready",   32'(bus.instr_ready),   32'd0);
      chk("rst write",   32'(bus.fp_reg_write),  32'd0);
      chk("rst illegal", 32'(bus.illegal_instr), 32'd0);
      chk("rst retire",  32'(bus.retire_count),  32'd0);
      chk_dp(vecs[3], "rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst ready", 32'(bus.instr_ready), 32'd1);

      for (int unsigned i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Reset in cycle T+5 of a div aborts it without a strobe.
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr = 32'hEDEF0005;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      for (int unsigned k = 1; k <= 4; k++) begin
         chk($sformatf("abort write c%0d", k), 32'(bus.fp_reg_write), 32'd0);
         @(negedge clk);
      end
      rst = 1'b1;                          // high through cycle T+5
      @(negedge clk);
      chk("abort rst ready",  32'(bus.instr_ready),  32'd0);
      chk("abort rst write",  32'(bus.fp_reg_write), 32'd0);
      chk("abort rst retire", 32'(bus.retire_count), 32'd0);
      rst = 1'b0;
      exp_retire = '0;
      for (int unsigned k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("abort after ready c%0d", k), 32'(bus.instr_ready), 32'd1);
         chk($sformatf("abort after write c%0d", k), 32'(bus.fp_reg_write), 32'd0);
      end

      // 65535 back-to-back adds bring the counter to 16'hFFFF.
      bus.instr = 32'h44A41000;
      bus.instr_valid = 1'b1;
      strobes = 0;
      cycles = 0;
      while (strobes < 65535 && cycles < 140000) begin
         @(negedge clk);
         cycles++;
         if (bus.fp_reg_write) begin
            strobes++;
            if (strobes == 65535) bus.instr_valid = 1'b0;
         end
      end
      bus.instr_valid = 1'b0;
      chk("wrap strobes", strobes, 32'd65535);
      @(negedge clk);
      chk("wrap retire_ffff", 32'(bus.retire_count), 32'h0000FFFF);
      exp_retire = 16'hFFFF;
      run_vec(vecs[0], 100);               // wraps retire_count to 0

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
